// File: rtl/tetris_pkg.sv
// Shared Tetris playfield constants, cell codes and the RAM arbiter state type.
package tetris_pkg;

  localparam int COLS   = 10;
  localparam int ROWS   = 20;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 4;

  typedef enum logic [3:0] {
    CELL_EMPTY   = 4'd0,
    CELL_I       = 4'd1,
    CELL_O       = 4'd2,
    CELL_T       = 4'd3,
    CELL_S       = 4'd4,
    CELL_Z       = 4'd5,
    CELL_J       = 4'd6,
    CELL_L       = 4'd7,
    CELL_GARBAGE = 4'd8
  } cell_e;

  typedef enum logic [1:0] {SYNC_WAIT, VBLANK, ACTIVE} arb_state_e;

  function automatic logic [ADDR_W-1:0] cell_addr(input int row, input int col);
    return ADDR_W'(row * COLS + col);
  endfunction

endpackage

// File: rtl/gravity_timer.sv
// Counts frames and emits a drop pulse every drop_div+1 unpaused frames.
module gravity_timer #(
  parameter int DIV_W = 5
) (
  input  logic             pixclk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             pause,
  input  logic [DIV_W-1:0] drop_div,
  output logic             drop_tick
);

  logic [DIV_W-1:0] frame_cnt;

  // >= rather than == so lowering drop_div below the count fires promptly
  assign drop_tick = frame_tick & ~pause & (frame_cnt >= drop_div);

  always_ff @(posedge pixclk) begin
    if (rst)                      frame_cnt <= '0;
    else if (frame_tick && !pause) frame_cnt <= drop_tick ? '0 : frame_cnt + 1'b1;
  end

endmodule

// File: rtl/playfield_ram_arbiter.sv
// Shares the playfield RAM: renderer reads always win, game accesses only in
// blanking windows framed by VDE/vsync. Also paces game logic with frame/drop ticks.
module playfield_ram_arbiter #(
  parameter int ADDR_W        = tetris_pkg::ADDR_W,
  parameter int DATA_W        = tetris_pkg::DATA_W,
  parameter int DIV_W         = 5,
  parameter bit HBLANK_ACCESS = 1'b0
) (
  input  logic              pixclk,
  input  logic              rst,
  input  logic              VDE,
  input  logic [1:0]        CD,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  input  logic              g_req,
  input  logic              g_we,
  input  logic [ADDR_W-1:0] g_addr,
  input  logic [DATA_W-1:0] g_wdata,
  output logic              g_gnt,
  output logic [DATA_W-1:0] g_rdata,
  output logic              g_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [DIV_W-1:0]  drop_div,
  input  logic              pause,
  output logic              frame_tick,
  output logic              drop_tick,
  output logic              overrun
);

  localparam int RD_LAT = 2;

  tetris_pkg::arb_state_e state_q, state_d;

  logic              vs_prev, vde_prev, vsync_fall;
  logic              win_open, win_close;
  logic              rd_issue, gr_issue;
  logic [ADDR_W-1:0] addr_q;
  logic [RD_LAT-1:0] r_vld_pipe, g_vld_pipe;
  logic              hsync_unused;

  assign hsync_unused = CD[0];
  assign vsync_fall   = vs_prev & ~CD[1];

  always_ff @(posedge pixclk) begin
    if (rst) begin
      state_q  <= tetris_pkg::SYNC_WAIT;
      vs_prev  <= 1'b1;
      vde_prev <= 1'b0;
    end else begin
      state_q  <= state_d;
      vs_prev  <= CD[1];
      vde_prev <= VDE;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_open  = 1'b0;
    win_close = 1'b0;
    case (state_q)
      tetris_pkg::SYNC_WAIT: if (vsync_fall) state_d = tetris_pkg::VBLANK;
      tetris_pkg::VBLANK: begin
        win_open  = ~VDE;
        win_close = VDE;
        if (VDE) state_d = tetris_pkg::ACTIVE;
      end
      tetris_pkg::ACTIVE: begin
        win_open  = HBLANK_ACCESS & ~VDE;
        win_close = HBLANK_ACCESS & VDE & ~vde_prev;
        if (vsync_fall) state_d = tetris_pkg::VBLANK;
      end
      default: state_d = tetris_pkg::SYNC_WAIT;
    endcase
  end

  // Idle cycles keep the last address on the RAM bus to avoid needless toggling
  always_comb begin
    ram_addr  = addr_q;
    ram_we    = 1'b0;
    ram_wdata = '0;
    g_gnt     = 1'b0;
    rd_issue  = 1'b0;
    gr_issue  = 1'b0;
    if (rst) begin
      ram_addr = '0;
    end else if (r_en) begin
      ram_addr = r_addr;
      rd_issue = 1'b1;
    end else if (g_req && win_open) begin
      g_gnt     = 1'b1;
      ram_addr  = g_addr;
      ram_we    = g_we;
      ram_wdata = g_wdata;
      gr_issue  = ~g_we;
    end
  end

  always_ff @(posedge pixclk) begin
    if (rst) begin
      addr_q     <= '0;
      r_vld_pipe <= '0;
      g_vld_pipe <= '0;
      r_data     <= '0;
      g_rdata    <= '0;
      frame_tick <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      addr_q     <= ram_addr;
      r_vld_pipe <= {r_vld_pipe[RD_LAT-2:0], rd_issue};
      g_vld_pipe <= {g_vld_pipe[RD_LAT-2:0], gr_issue};
      if (r_vld_pipe[0]) r_data  <= ram_rdata;
      if (g_vld_pipe[0]) g_rdata <= ram_rdata;
      frame_tick <= vsync_fall;
      if (g_req && win_close && !g_gnt) overrun <= 1'b1;
    end
  end

  assign r_valid  = r_vld_pipe[RD_LAT-1];
  assign g_rvalid = g_vld_pipe[RD_LAT-1];

  gravity_timer #(.DIV_W(DIV_W)) u_grav (
    .pixclk     (pixclk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .pause      (pause),
    .drop_div   (drop_div),
    .drop_tick  (drop_tick)
  );

endmodule

// File: tb/tb_playfield_ram_arbiter.sv
// Random renderer/game traffic over a miniature video frame, run against both
// hblank settings at once and scored against a frame-level reference model.
module tb_playfield_ram_arbiter;

  localparam int H_ACT = 6, H_TOT = 10, V_ACT = 3, V_TOT = 7, VS_LINE = 5;
  localparam int NFRAMES = 30;
  localparam int NCYC = NFRAMES * H_TOT * V_TOT;

  logic       pixclk = 1'b0;
  logic       rst, VDE, r_en, pause;
  logic [1:0] CD;
  logic [7:0] r_addr;
  logic [4:0] drop_div;

  logic       g_req [2], g_we [2], g_gnt [2], g_rvalid [2], r_valid [2];
  logic       ram_we [2], frame_tick [2], drop_tick [2], overrun [2];
  logic [7:0] g_addr [2], ram_addr [2];
  logic [3:0] g_wdata [2], g_rdata [2], r_data [2], ram_wdata [2], ram_rdata [2];
  logic [3:0] mem [2][256] = '{default: '0};

  always #5 pixclk = ~pixclk;

  playfield_ram_arbiter #(.HBLANK_ACCESS(1'b0)) dut0 (
    .pixclk(pixclk), .rst(rst), .VDE(VDE), .CD(CD),
    .r_en(r_en), .r_addr(r_addr), .r_data(r_data[0]), .r_valid(r_valid[0]),
    .g_req(g_req[0]), .g_we(g_we[0]), .g_addr(g_addr[0]), .g_wdata(g_wdata[0]),
    .g_gnt(g_gnt[0]), .g_rdata(g_rdata[0]), .g_rvalid(g_rvalid[0]),
    .ram_addr(ram_addr[0]), .ram_we(ram_we[0]), .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]),
    .drop_div(drop_div), .pause(pause),
    .frame_tick(frame_tick[0]), .drop_tick(drop_tick[0]), .overrun(overrun[0])
  );

  playfield_ram_arbiter #(.HBLANK_ACCESS(1'b1)) dut1 (
    .pixclk(pixclk), .rst(rst), .VDE(VDE), .CD(CD),
    .r_en(r_en), .r_addr(r_addr), .r_data(r_data[1]), .r_valid(r_valid[1]),
    .g_req(g_req[1]), .g_we(g_we[1]), .g_addr(g_addr[1]), .g_wdata(g_wdata[1]),
    .g_gnt(g_gnt[1]), .g_rdata(g_rdata[1]), .g_rvalid(g_rvalid[1]),
    .ram_addr(ram_addr[1]), .ram_we(ram_we[1]), .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]),
    .drop_div(drop_div), .pause(pause),
    .frame_tick(frame_tick[1]), .drop_tick(drop_tick[1]), .overrun(overrun[1])
  );

  // single-port RAM, one cycle registered read, read-before-write
  always @(posedge pixclk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_we[d]) mem[d][ram_addr[d]] <= ram_wdata[d];
      ram_rdata[d] <= mem[d][ram_addr[d]];
    end
  end

  int n_chk = 0, n_err = 0, cyc = 0;

  task automatic check(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cycle %0d got %0h exp %0h", tag, d, cyc, got, exp);
    end
  endtask

  // reference model: frame-level view of the blanking windows plus a shadow board
  bit m_armed = 0, m_vblank = 0, m_prev_vs = 1, m_prev_vde = 0, m_ft = 0;
  bit m_ovr [2] = '{0, 0};
  int m_cnt = 0;
  int m_held [2] = '{0, 0};
  bit rv_q [2][4], gv_q [2][4];
  int rd_q [2][4], gd_q [2][4];
  int shadow [2][256];

  task automatic step(input int c);
    int  s, s2, e_addr;
    bit  fall, e_drop, open_w, close_w, e_gnt, e_we;
    s      = c % 4;
    s2     = (c + 2) % 4;
    fall   = !rst && m_prev_vs && !CD[1];
    e_drop = m_ft && !pause && (m_cnt >= int'(drop_div));
    for (int d = 0; d < 2; d++) begin
      open_w  = m_armed && !VDE && (m_vblank || d == 1);
      close_w = m_armed && VDE && !m_prev_vde && (m_vblank || d == 1);
      e_gnt   = !rst && !r_en && g_req[d] && open_w;
      e_we    = e_gnt && g_we[d];
      e_addr  = rst ? 0 : r_en ? int'(r_addr) : e_gnt ? int'(g_addr[d]) : m_held[d];
      check("g_gnt", d, 32'(g_gnt[d]), 32'(e_gnt));
      check("ram_we", d, 32'(ram_we[d]), 32'(e_we));
      check("ram_addr", d, 32'(ram_addr[d]), e_addr);
      if (e_we) check("ram_wdata", d, 32'(ram_wdata[d]), 32'(g_wdata[d]));
      check("r_valid", d, 32'(r_valid[d]), 32'(rv_q[d][s]));
      if (rv_q[d][s]) check("r_data", d, 32'(r_data[d]), rd_q[d][s]);
      check("g_rvalid", d, 32'(g_rvalid[d]), 32'(gv_q[d][s]));
      if (gv_q[d][s]) check("g_rdata", d, 32'(g_rdata[d]), gd_q[d][s]);
      check("frame_tick", d, 32'(frame_tick[d]), 32'(m_ft));
      check("drop_tick", d, 32'(drop_tick[d]), 32'(e_drop));
      check("overrun", d, 32'(overrun[d]), 32'(m_ovr[d]));
      rv_q[d][s] = 0;
      gv_q[d][s] = 0;
      if (rst) begin
        for (int k = 0; k < 4; k++) begin rv_q[d][k] = 0; gv_q[d][k] = 0; end
        m_ovr[d]  = 0;
        m_held[d] = 0;
      end else begin
        if (r_en) begin rv_q[d][s2] = 1; rd_q[d][s2] = shadow[d][r_addr]; end
        if (e_gnt && !g_we[d]) begin gv_q[d][s2] = 1; gd_q[d][s2] = shadow[d][g_addr[d]]; end
        if (e_we) shadow[d][g_addr[d]] = int'(g_wdata[d]);
        if (g_req[d] && close_w && !e_gnt) m_ovr[d] = 1;
        m_held[d] = e_addr;
      end
    end
    if (rst) begin
      m_armed = 0; m_vblank = 0; m_prev_vs = 1; m_prev_vde = 0; m_ft = 0; m_cnt = 0;
    end else begin
      if (m_ft && !pause) m_cnt = e_drop ? 0 : m_cnt + 1;
      m_ft = fall;
      if (m_vblank) m_vblank = !VDE;
      else if (fall) m_vblank = 1;
      m_armed    = m_armed || fall;
      m_prev_vs  = CD[1];
      m_prev_vde = VDE;
    end
  endtask

  bit         pend [2] = '{0, 0};
  bit         p_we [2];
  logic [7:0] p_addr [2];
  logic [3:0] p_wd [2];

  initial begin
    int h, v, frame;
    bit hog;
    h = 0; v = 0; frame = 0;
    rst = 1'b1; VDE = 1'b0; CD = 2'b11; r_en = 1'b0; r_addr = '0;
    drop_div = '0; pause = 1'b0;
    for (int d = 0; d < 2; d++) begin
      g_req[d] = 1'b0; g_we[d] = 1'b0; g_addr[d] = '0; g_wdata[d] = '0;
      for (int a = 0; a < 256; a++) shadow[d][a] = 0;
    end
    for (int c = 0; c < NCYC; c++) begin
      @(posedge pixclk); #1;
      cyc  = c;
      rst  = (c < 3) || (frame == 20 && v == 1 && (h == 3 || h == 4));
      VDE  = (h < H_ACT) && (v < V_ACT);
      CD   = {!(v == VS_LINE), !(h >= 8)};
      // renderer hogs the tail of vblank so a late game request misses the window
      hog  = (frame == 2 || frame == 22) && v == V_TOT - 1 && h >= 6;
      r_en = hog || ($urandom_range(99) < (VDE ? 50 : 15));
      r_addr = 8'($urandom_range(15));
      if (v == 3 && h == 0) begin
        if (frame < 6) begin drop_div = 5'd0; pause = 1'b0; end
        else if (frame < 14) begin drop_div = 5'd2; pause = 1'b0; end
        else if (frame < 16) begin drop_div = 5'd2; pause = 1'b1; end
        else begin drop_div = 5'($urandom_range(3)); pause = ($urandom_range(3) == 0); end
      end
      for (int d = 0; d < 2; d++) begin
        if (!rst && !pend[d] && (($urandom_range(99) < 8) || (hog && h == H_TOT - 1))) begin
          pend[d]   = 1;
          p_we[d]   = 1'($urandom_range(1));
          p_addr[d] = 8'($urandom_range(15));
          p_wd[d]   = 4'($urandom_range(15));
        end
        g_req[d]   = pend[d];
        g_we[d]    = p_we[d];
        g_addr[d]  = p_addr[d];
        g_wdata[d] = p_wd[d];
      end
      @(negedge pixclk);
      step(c);
      for (int d = 0; d < 2; d++) if (rst || g_gnt[d]) pend[d] = 0;
      h++;
      if (h == H_TOT) begin
        h = 0; v++;
        if (v == V_TOT) begin v = 0; frame++; end
      end
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/playfield_ram_arbiter.md
Name: playfield_ram_arbiter

Overview:
- Shares the single-port playfield RAM between the pixel renderer and the Tetris game logic.
- Frames access using the HDMI timing generator's VDE and sync outputs. Renderer reads always win; game-logic reads and writes are granted only in vertical blanking, so no frame ever shows a half-updated board.
- Also produces the per-frame tick and the gravity (drop) tick that pace game logic.

Parameters:
- ADDR_W, 8, playfield RAM address width (10x20 board = 200 cells)
- DATA_W, 4, cell word width (colour/occupied code)
- DIV_W, 5, width of gravity divider and frame counter
- HBLANK_ACCESS, 0, 1 = also grant game access in horizontal blanking of active lines

Ports:
- pixclk  in  1  pixel clock; only clock
- rst  in  1  synchronous, active-high reset
- VDE  in  1  video data enable from timing generator
- CD  in  2  {vsync, hsync} from timing generator; vsync active-low
- r_en  in  1  renderer read request (single-cycle, any cycle)
- r_addr  in  ADDR_W  renderer read address
- r_data  out  DATA_W  renderer read data
- r_valid  out  1  r_data valid
- g_req  in  1  game request; held until g_gnt
- g_we  in  1  1 = write, 0 = read
- g_addr  in  ADDR_W  game address
- g_wdata  in  DATA_W  game write data
- g_gnt  out  1  one-cycle grant; request consumed this cycle
- g_rdata  out  DATA_W  game read data
- g_rvalid  out  1  g_rdata valid
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, 1-cycle registered latency
- drop_div  in  DIV_W  frames per gravity step minus 1
- pause  in  1  freezes the gravity counter
- frame_tick  out  1  one-cycle pulse per frame
- drop_tick  out  1  one-cycle gravity pulse
- overrun  out  1  sticky: game request was pending when a window closed

Behaviour:
- Reset values:
  - All outputs are 0.
  - FSM = SYNC_WAIT.
  - Frame counter = 0.
  - Registered previous-vsync = 1.
- vsync_fall is CD[1] registered-previous = 1 and current = 0. One cycle of edge-detect delay is accepted.
- FSM states and transitions:
  - SYNC_WAIT: no game grants. On vsync_fall, go to VBLANK.
  - VBLANK: game window open. On VDE = 1, go to ACTIVE, and the window closes in that same cycle.
  - ACTIVE: game window open only when HBLANK_ACCESS = 1 and VDE = 0. On vsync_fall, go to VBLANK.
- Arbitration, evaluated per cycle:
  - r_en = 1: RAM driven from r_addr, ram_we = 0, g_gnt = 0. The renderer always wins, in every state.
  - Otherwise, g_req = 1 and window open: g_gnt = 1, RAM driven from g_addr/g_we/g_wdata.
  - Otherwise ram_we = 0, and ram_addr holds its last value.
  - ram_* outputs are combinational from the arbitration decision; the decision uses registered state only.
- Read latency:
  - Renderer: r_valid = 1 and r_data = ram_rdata exactly 2 cycles after r_en.
  - Game read grant: g_rvalid/g_rdata exactly 2 cycles after g_gnt.
  - A game write grant produces no g_rvalid.
  - Read-tag pipeline is 2 deep, so back-to-back reads give back-to-back valids.
- Window close:
  - If g_req = 1 with no grant in the cycle the window closes (VBLANK to ACTIVE, or hblank ends), set overrun.
  - overrun is cleared only by rst.
  - The request stays pending and is served in the next window.
- Frame and gravity:
  - frame_tick pulses in the cycle after vsync_fall, including the first one out of SYNC_WAIT.
  - On frame_tick with pause = 0: if frame_cnt >= drop_div, then drop_tick = 1 (same cycle as frame_tick) and frame_cnt = 0; else frame_cnt + 1.
  - drop_div = 0 gives a drop every frame.
  - Lowering drop_div below frame_cnt fires a drop on the next frame_tick.
  - pause = 1: frame_tick still pulses; frame_cnt and drop_tick are frozen/0.
- Reset mid-operation:
  - In-flight read tags are flushed; no valid pulses after rst.
  - FSM returns to SYNC_WAIT; no grant until the next vsync fall.

Decomposition:
- Shared package tetris_pkg holds:
  - the playfield constants (COLS = 10, ROWS = 20, ADDR_W, DATA_W)
  - the cell-code enum
  - the arbiter state typedef {SYNC_WAIT, VBLANK, ACTIVE}
- One natural sub-module: gravity_timer (frame counter, drop_div compare, pause), fed by frame_tick.

Test Plan:
- Reset, then idle through one frame with g_req = 1 before the first vsync fall -> no g_gnt until after the first vsync_fall; frame_tick = 1 once; drop_tick = 1 with drop_div = 0.
- VBLANK, g_req write addr 5, data 0xA; then renderer r_en addr 5 in the next active line -> g_gnt one cycle; r_valid 2 cycles after r_en with r_data = 0xA.
- VBLANK, r_en and g_req in the same cycle -> renderer served, g_gnt = 0; g_gnt the next cycle (r_en = 0); r_valid then g_rvalid on consecutive cycles.
- g_req raised 1 cycle before VDE rises, with r_en held high -> no grant, overrun = 1; grant in the next vblank; overrun stays 1 until rst.
- drop_div = 2 over 7 frames -> drop_tick on frames 3 and 6. Then pause = 1 for 2 frames -> frame_tick continues, no drop_tick, frame_cnt unchanged.
- HBLANK_ACCESS = 1, g_req during the VDE = 0 gap of an active line -> g_gnt in hblank; with HBLANK_ACCESS = 0 -> no grant until vblank.
